sprite_load_scheduler: RTL

//  Time-multiplexes one shared sprite bitmap ROM among NUM_SPRITES sprite_renderer

---
 rtl/sprite_load_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sprite_load_scheduler.sv
// Sprite load scheduler: shares one bitmap ROM among NUM_SPRITES renderers by
// issuing one fixed-length load slot per sprite during horizontal blanking,
// generates per-sprite hstart/vstart strobes and latches a per-frame
// sprite-vs-sprite collision mask.
module sprite_load_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int HPOS_START  = 256,
    parameter int SLOT_CYCLES = 4,
    parameter int ROW_BITS    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [8:0]                      hpos,
    input  logic [8:0]                      vpos,
    input  logic                            vsync,
    input  logic [NUM_SPRITES-1:0]          sprite_en,
    input  logic [8*NUM_SPRITES-1:0]        sprite_x,
    input  logic [8*NUM_SPRITES-1:0]        sprite_y,
    input  logic [ROW_BITS*NUM_SPRITES-1:0] rom_addr_in,
    input  logic [NUM_SPRITES-1:0]          sprite_gfx,
    output logic [ROW_BITS-1:0]             rom_addr,
    output logic [NUM_SPRITES-1:0]         load,
    output logic [NUM_SPRITES-1:0]         hstart,
    output logic [NUM_SPRITES-1:0]         vstart,
    output logic [NUM_SPRITES-1:0]         collision,
    output logic                            busy
);

    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_SPRITES-1:0] acc_q, acc_d;
    logic [NUM_SPRITES-1:0] collision_q, collision_d;
    logic                   vsync_q;
    logic [NUM_SPRITES-1:0] hits;
    logic                   vsyncRise;

    // Scheduler state, slot index and in-slot cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start at the first blank column, step through the slots,
    // and abandon the sequence whenever a new line begins (hpos back to 0).
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hpos == 9'(HPOS_START)) begin
                    state_d = SLOT;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            end
            SLOT: begin
                if (hpos == 9'd0) begin
                    state_d = IDLE;
                    slot_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (slot_q == SLOT_W'(NUM_SPRITES - 1)) begin
                        state_d = DONE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (hpos == 9'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // ROM steering and load strobes; a disabled sprite still owns its slot time.
    always_comb begin
        busy     = (state_q == SLOT);
        load     = '0;
        rom_addr = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            if (busy && (slot_q == SLOT_W'(k))) begin
                rom_addr = rom_addr_in[k*ROW_BITS +: ROW_BITS];
                load[k]  = sprite_en[k];
            end
        end
    end

    // Position strobes are plain compares against the zero-extended coordinates.
    always_comb begin
        hstart = '0;
        vstart = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            hstart[k] = ({1'b0, sprite_x[k*8 +: 8]} == hpos) && sprite_en[k];
            vstart[k] = ({1'b0, sprite_y[k*8 +: 8]} == vpos) && sprite_en[k];
        end
    end

    // Per-cycle overlap detection and frame accumulation; a hit on the vsync
    // edge cycle belongs to the frame being closed.
    always_comb begin
        hits = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            hits[k] = sprite_gfx[k] && (|(sprite_gfx & ~(NUM_SPRITES'(1) << k)));
        end
        vsyncRise   = vsync && !vsync_q;
        acc_d       = acc_q | hits;
        collision_d = collision_q;
        if (vsyncRise) begin
            collision_d = acc_q | hits;
            acc_d       = '0;
        end
    end

    // Collision accumulator, reported mask and vsync edge-detect register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            collision_q <= '0;
            vsync_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            collision_q <= collision_d;
            vsync_q     <= vsync;
        end
    end

    assign collision = collision_q;

endmodule
